// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg -- shared definitions for the ID channel queue.
//
// Contents:
//   ID_W_DEFAULT  default ID width in bits
//   DEPTH_DEFAULT default entries per channel queue (power of two, >= 2)
//   stateType     controller state encoding (INIT=0, BIST=1, RUN=2)
// ---------------------------------------------------------------------------
package id_pkg;

  localparam int ID_W_DEFAULT  = 8;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    BIST = 2'd1,
    RUN  = 2'd2
  } stateType;

endpackage

// File: rtl/id_fifo.sv
// ---------------------------------------------------------------------------
// id_fifo -- single-channel ID queue.
//
// Ports:
//   clk    in   clock, all state on rising edge
//   reset  in   asynchronous active-high reset (pointers/count to 0)
//   flush  in   synchronous clear of pointers/count
//   push   in   enqueue din (ignored when full)
//   pop    in   dequeue head (ignored when empty)
//   din    in   ID_W  data to enqueue
//   empty  out  count == 0
//   full   out  count == DEPTH
//   head   out  ID_W  entry at read pointer, read combinationally
// ---------------------------------------------------------------------------
module id_fifo
  import id_pkg::*;
#(
  parameter int ID_W  = ID_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] din,
  output logic            empty,
  output logic            full,
  output logic [ID_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: stale entries remain visible on head when empty.
  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= din;
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rdPtr];

endmodule

// File: rtl/id_channel_queue.sv
// ---------------------------------------------------------------------------
// id_channel_queue -- two ID queues (ch1/ch2) behind an INIT/BIST/RUN
// controller.
//
// Optional feature macro: ID_QUEUE_BIST_EN
//   defined   : BIST state plus a pattern generator filling both queues
//   undefined : start_test goes INIT->RUN directly, end_test_global unused
//
// Ports:
//   clk              in   clock
//   reset            in   asynchronous active-high reset
//   start_test       in   leave INIT
//   end_test_global  in   leave BIST
//   id_in            in   ID_W  ID to enqueue
//   id_valid         in   push request
//   id_ch            in   target channel (0=ch1, 1=ch2)
//   clearID1/2       in   pop head of ch1/ch2
//   emptyID1/2       out  queue empty flags
//   fullID1/2        out  queue full flags
//   id_ready         out  push to id_ch accepted this cycle
//   id_out1/2        out  ID_W  head entry of each queue
//   overflow         out  sticky flag: a push was dropped on a full queue
// ---------------------------------------------------------------------------
module id_channel_queue
  import id_pkg::*;
#(
  parameter int ID_W  = ID_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_test,
  input  logic            end_test_global,
  input  logic [ID_W-1:0] id_in,
  input  logic            id_valid,
  input  logic            id_ch,
  input  logic            clearID1,
  input  logic            clearID2,
  output logic            emptyID1,
  output logic            emptyID2,
  output logic            fullID1,
  output logic            fullID2,
  output logic            id_ready,
  output logic [ID_W-1:0] id_out1,
  output logic [ID_W-1:0] id_out2,
  output logic            overflow
);

  stateType        state;
  stateType        stateNext;
  logic            flush;
  logic            push1;
  logic            push2;
  logic            pop1;
  logic            pop2;
  logic [ID_W-1:0] din1;
  logic [ID_W-1:0] din2;
  logic            idReady;

`ifdef ID_QUEUE_BIST_EN
  logic [ID_W-1:0] bistPattern;
  logic            bistTarget;   // 0 = ch1, 1 = ch2
`else
  logic            unusedEndTest;
  assign unusedEndTest = end_test_global;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    flush     = 1'b0;
    push1     = 1'b0;
    push2     = 1'b0;
    pop1      = 1'b0;
    pop2      = 1'b0;
    din1      = id_in;
    din2      = id_in;
    idReady   = 1'b0;
    case (state)
      INIT: begin
        flush = 1'b1;
`ifdef ID_QUEUE_BIST_EN
        if (start_test) stateNext = BIST;
`else
        if (start_test) stateNext = RUN;
`endif
      end
`ifdef ID_QUEUE_BIST_EN
      BIST: begin
        // External pushes are ignored; the generator owns the write side.
        pop1 = clearID1;
        pop2 = clearID2;
        din1 = bistPattern;
        din2 = bistPattern;
        if (!bistTarget) push1 = !fullID1;
        else             push2 = !fullID2;
        if (end_test_global) stateNext = RUN;
      end
`endif
      RUN: begin
        pop1    = clearID1;
        pop2    = clearID2;
        idReady = id_ch ? !fullID2 : !fullID1;
        push1   = id_valid && idReady && !id_ch;
        push2   = id_valid && idReady && id_ch;
      end
      default: stateNext = INIT;
    endcase
  end

`ifdef ID_QUEUE_BIST_EN
  // Target alternates every BIST cycle; the pattern only advances on an
  // accepted push so a skipped value is offered again later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bistPattern <= ID_W'(1);
      bistTarget  <= 1'b0;
    end else if (state == BIST) begin
      bistTarget <= !bistTarget;
      if (push1 || push2) bistPattern <= bistPattern + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   overflow <= 1'b0;
    else if (state == RUN && id_valid && !idReady) overflow <= 1'b1;
  end

  assign id_ready = idReady;

  id_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) ch1Fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push1),
    .pop   (pop1),
    .din   (din1),
    .empty (emptyID1),
    .full  (fullID1),
    .head  (id_out1)
  );

  id_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) ch2Fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push2),
    .pop   (pop2),
    .din   (din2),
    .empty (emptyID2),
    .full  (fullID2),
    .head  (id_out2)
  );

endmodule

// File: tb/tb_id_channel_queue.sv
// ---------------------------------------------------------------------------
// tb_id_channel_queue -- self-checking bench for id_channel_queue.
// The stimulus process queues the IDs it expects each channel to deliver;
// a monitor compares the head against that queue on every pop cycle.
// Flag and head checks after specific steps are made inline.
// ---------------------------------------------------------------------------
module tb_id_channel_queue;

  localparam int ID_W  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start_test = 1'b0;
  logic            end_test_global = 1'b0;
  logic [ID_W-1:0] id_in = '0;
  logic            id_valid = 1'b0;
  logic            id_ch = 1'b0;
  logic            clearID1 = 1'b0;
  logic            clearID2 = 1'b0;
  logic            emptyID1, emptyID2, fullID1, fullID2, id_ready, overflow;
  logic [ID_W-1:0] id_out1, id_out2;

  int tests = 0;
  int failed = 0;
  logic [ID_W-1:0] exp1 [$];
  logic [ID_W-1:0] exp2 [$];

  id_channel_queue #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_test      (start_test),
    .end_test_global (end_test_global),
    .id_in           (id_in),
    .id_valid        (id_valid),
    .id_ch           (id_ch),
    .clearID1        (clearID1),
    .clearID2        (clearID2),
    .emptyID1        (emptyID1),
    .emptyID2        (emptyID2),
    .fullID1         (fullID1),
    .fullID2         (fullID2),
    .id_ready        (id_ready),
    .id_out1         (id_out1),
    .id_out2         (id_out2),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each pop cycle, compare the head with the oldest expected ID.
  initial begin
    forever begin
      @(negedge clk);
      if (clearID1) begin
        if (exp1.size() > 0) begin
          check("pop1 not empty", emptyID1, 1'b0);
          check("pop1 head", id_out1, exp1.pop_front());
        end else begin
          check("pop1 on empty stays empty", emptyID1, 1'b1);
        end
      end
      if (clearID2) begin
        if (exp2.size() > 0) begin
          check("pop2 not empty", emptyID2, 1'b0);
          check("pop2 head", id_out2, exp2.pop_front());
        end else begin
          check("pop2 on empty stays empty", emptyID2, 1'b1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset emptyID1", emptyID1, 1'b1);
    check("reset emptyID2", emptyID2, 1'b1);
    check("reset fullID1", fullID1, 1'b0);
    check("reset fullID2", fullID2, 1'b0);
    check("reset id_ready", id_ready, 1'b0);
    check("reset overflow", overflow, 1'b0);
    reset = 1'b0;
    tick();

    // Pushes in INIT are ignored
    id_valid = 1'b1; id_ch = 1'b0; id_in = 8'h33;
    #1 check("INIT id_ready", id_ready, 1'b0);
    tick();
    id_valid = 1'b0;
    check("INIT push ignored", emptyID1, 1'b1);

    start_test = 1'b1;
    tick();
    start_test = 1'b0;

`ifdef ID_QUEUE_BIST_EN
    // BIST: ch1 gets 01,03 and ch2 gets 02,04 in four cycles
    repeat (4) tick();
    check("BIST id_out1", id_out1, 8'h01);
    check("BIST id_out2", id_out2, 8'h02);
    check("BIST emptyID1", emptyID1, 1'b0);
    check("BIST emptyID2", emptyID2, 1'b0);
    check("BIST fullID1", fullID1, 1'b0);
    check("BIST fullID2", fullID2, 1'b0);
    check("BIST id_ready", id_ready, 1'b0);
    // The exit cycle is still BIST, so 0x05 lands in ch1
    exp1.push_back(8'h01); exp1.push_back(8'h03); exp1.push_back(8'h05);
    exp2.push_back(8'h02); exp2.push_back(8'h04);
    end_test_global = 1'b1;
    tick();
    end_test_global = 1'b0;
    id_ch = 1'b0;
    #1 check("RUN id_ready after BIST", id_ready, 1'b1);
    clearID1 = 1'b1; clearID2 = 1'b1;
    tick();
    tick();
    clearID2 = 1'b0;
    tick();
    clearID1 = 1'b0;
    check("BIST drained emptyID1", emptyID1, 1'b1);
    check("BIST drained emptyID2", emptyID2, 1'b1);
`endif

    // First push to ch1
    id_valid = 1'b1; id_ch = 1'b0; id_in = 8'hA5;
    exp1.push_back(8'hA5);
    tick();
    id_valid = 1'b0;
    check("push A5 emptyID1", emptyID1, 1'b0);
    check("push A5 id_out1", id_out1, 8'hA5);
    check("push A5 emptyID2", emptyID2, 1'b1);

    // Pop A5, then pop on empty
    clearID1 = 1'b1;
    tick();
    tick();
    clearID1 = 1'b0;
    check("empty pop emptyID1", emptyID1, 1'b1);
    check("empty pop overflow", overflow, 1'b0);
    id_valid = 1'b1; id_ch = 1'b0; id_in = 8'h77;
    exp1.push_back(8'h77);
    tick();
    id_valid = 1'b0;
    check("after empty pop id_out1", id_out1, 8'h77);

    // Fill ch2 with 0x10..0x13
    for (int i = 0; i < 4; i++) begin
      id_valid = 1'b1; id_ch = 1'b1; id_in = 8'h10 + 8'(i);
      #1 check("ch2 fill id_ready", id_ready, 1'b1);
      exp2.push_back(8'h10 + 8'(i));
      tick();
    end
    id_valid = 1'b0; id_ch = 1'b0;
    #1 check("ch1 id_ready while ch2 full", id_ready, 1'b1);
    id_valid = 1'b1; id_ch = 1'b1; id_in = 8'h14;
    #1 check("ch2 full id_ready", id_ready, 1'b0);
    check("ch2 fullID2", fullID2, 1'b1);
    tick();
    id_valid = 1'b0;
    check("overflow set", overflow, 1'b1);
    check("overflow id_out2", id_out2, 8'h10);
    check("overflow fullID2", fullID2, 1'b1);

    // Full ch2: pop and push together, only the pop happens
    clearID2 = 1'b1; id_valid = 1'b1; id_ch = 1'b1; id_in = 8'h15;
    #1 check("full push+pop id_ready", id_ready, 1'b0);
    tick();
    clearID2 = 1'b0; id_valid = 1'b0;
    check("pop-only fullID2", fullID2, 1'b0);
    check("pop-only id_out2", id_out2, 8'h11);
    id_valid = 1'b1; id_ch = 1'b1; id_in = 8'h16;
    #1 check("refill id_ready", id_ready, 1'b1);
    exp2.push_back(8'h16);
    tick();
    id_valid = 1'b0;
    check("refill fullID2", fullID2, 1'b1);

    // Simultaneous pops on both channels
    clearID1 = 1'b1; clearID2 = 1'b1;
    tick();
    clearID1 = 1'b0; clearID2 = 1'b0;
    check("dual pop emptyID1", emptyID1, 1'b1);
    check("dual pop id_out2", id_out2, 8'h12);

    // Push and pop together on a non-full ch2: count stays at 3
    clearID2 = 1'b1; id_valid = 1'b1; id_ch = 1'b1; id_in = 8'h18;
    exp2.push_back(8'h18);
    tick();
    clearID2 = 1'b0; id_valid = 1'b0;
    check("push+pop fullID2", fullID2, 1'b0);
    check("push+pop emptyID2", emptyID2, 1'b0);
    check("push+pop id_out2", id_out2, 8'h13);
    id_valid = 1'b1; id_ch = 1'b1; id_in = 8'h19;
    exp2.push_back(8'h19);
    tick();
    id_valid = 1'b0;
    check("count 3 plus one fullID2", fullID2, 1'b1);

    // Asynchronous reset with both queues holding data
    id_valid = 1'b1; id_ch = 1'b0; id_in = 8'h21;
    exp1.push_back(8'h21);
    tick();
    id_valid = 1'b0;
    check("pre-reset emptyID1", emptyID1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async reset emptyID1", emptyID1, 1'b1);
    check("async reset emptyID2", emptyID2, 1'b1);
    check("async reset fullID2", fullID2, 1'b0);
    check("async reset overflow", overflow, 1'b0);
    check("async reset id_ready", id_ready, 1'b0);
    exp1.delete();
    exp2.delete();
    tick();
    reset = 1'b0;
    id_ch = 1'b1;
    tick();
    check("post-reset INIT id_ready", id_ready, 1'b0);
    check("post-reset emptyID2", emptyID2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/id_channel_queue.md
ID_CHANNEL_QUEUE -- requirements
Module: id_channel_queue

Interface
REQ-001 SHALL have parameter ID_W, default 8, ID width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per channel queue (power of two, >=2).
REQ-003 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high.
REQ-005 SHALL have ports: start_test  input  1  leave INIT; end_test_global  input  1  leave BIST.
REQ-006 SHALL have ports: id_in  input  ID_W  ID to enqueue; id_valid  input  1  push request; id_ch  input  1  target channel (0=ch1, 1=ch2).
REQ-007 SHALL have ports: clearID1, clearID2  input  1 each  pop head of ch1/ch2 queue.
REQ-008 SHALL have ports: emptyID1, emptyID2  output  1 each  queue empty flags.
REQ-009 SHALL have ports: fullID1, fullID2  output  1 each  queue full flags; id_ready  output  1  push to id_ch accepted this cycle.
REQ-010 SHALL have ports: id_out1, id_out2  output  ID_W each  head entry of each queue; overflow  output  1  sticky dropped-push flag.

Function
REQ-011 SHALL implement FSM INIT, BIST, RUN; INIT->BIST on start_test=1 (RUN if BIST compiled out); BIST->RUN on end_test_global=1; RUN terminal until reset.
REQ-012 SHALL hold both queues flushed (count 0) while in INIT; pushes and pops ignored in INIT.
REQ-013 SHALL, in RUN, push id_in into queue id_ch on a cycle with id_valid=1 and id_ready=1.
REQ-014 SHALL drive id_ready = state RUN and selected queue not full (combinational); full-queue push with id_valid=1 dropped and overflow set to 1 next edge.
REQ-015 SHALL pop on clearIDn=1 when queue n non-empty in BIST or RUN; pop on empty queue ignored, no error.
REQ-016 SHALL, on simultaneous push and pop of same non-full queue, do both; count unchanged; pointers wrap modulo DEPTH.
REQ-017 SHALL not accept push on a full queue even with simultaneous pop (id_ready low).
REQ-018 SHALL update emptyIDn/fullIDn as registered-count decodes: change visible the cycle after the causing edge.
REQ-019 SHALL present id_outn = head entry combinationally from storage; value undefined-but-stable (last written) when empty.
REQ-020 SHALL treat clearID1 and clearID2 independently; simultaneous pops on both channels both take effect.

Reset
REQ-021 SHALL on reset=1 force state INIT, both counts/pointers 0, overflow 0, BIST pattern 0x01, emptyID1/2=1, fullID1/2=0, id_ready=0.
REQ-022 SHALL, on reset mid-operation, discard all queued entries immediately (asynchronous).

Configuration
REQ-023 SHALL, with ID_QUEUE_BIST_EN defined, include BIST generator: in BIST each cycle push pattern value alternately to ch1 then ch2 (starting ch1) when target not full, pattern incrementing by 1 per accepted push, wrapping 2^ID_W-1->0; skipped (not advanced) when target full.
REQ-024 SHALL, without ID_QUEUE_BIST_EN, omit BIST state and generator; start_test goes INIT->RUN; end_test_global ignored.
REQ-025 SHALL ignore id_valid/id_in in BIST.

Structure
REQ-026 SHALL place state encoding (INIT=0, BIST=1, RUN=2) and default ID_W/DEPTH constants in shared package id_pkg.
REQ-027 SHALL instantiate one sub-module id_fifo (single-channel queue, push/pop/empty/full/head) twice.

Verification
REQ-028 Reset then start_test=1, id_valid=1,id_ch=0,id_in=0xA5 one cycle -> next cycle emptyID1=0, id_out1=0xA5, emptyID2=1.
REQ-029 Push 4 IDs 0x10..0x13 to ch2 -> fullID2=1, id_ready=0 for id_ch=1; 5th push 0x14 -> overflow=1, id_out2=0x10.
REQ-030 Full ch2 with clearID2=1 and push same cycle -> pop only, count 3, id_out2=0x11; next push accepted.
REQ-031 Empty ch1, clearID1=1 -> emptyID1 stays 1, overflow stays 0, no pointer change.
REQ-032 (BIST_EN) start_test, 4 cycles in BIST -> id_out1=0x01, id_out2=0x02, counts 2/2; end_test_global=1 -> RUN, id_ready=1.
REQ-033 Assert reset with both queues non-empty -> emptyID1/2=1, overflow=0 immediately, before next clk edge.
